seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised time-multiplexed driver for an N-digit common-anode/common-cathode 7-segment display.
- Successor to the fixed 4-digit scan display block. Adds:
  - configurable digit count and scan rate
  - hex/symbol decode modes
  - per-digit decimal points
  - leading-zero blanking
  - 8-level brightness PWM
  - frame-coherent input snapshot
- Sits between the datapath (counters, timers, measurement results) and the board LED pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot; must be a multiple of 8 and >= 16.
- HEX_MODE, 0, 1 = codes 10..15 render A,b,C,d,E,F; 0 = code 10 blank, 11 minus (G only), 12..15 blank.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when pin is 0.
- DIG_ACTIVE_LOW, 0, 1 = digit enabled when pin is 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- digits_i  in  4*N_DIGITS  packed BCD/hex codes; nibble k = digit k, digit 0 rightmost
- dp_i  in  N_DIGITS  decimal point request per digit
- lz_blank_i  in  1  leading-zero suppression enable
- bright_i  in  3  brightness level 0..7 (7 = full)
- seg_o  out  7  segments, bit0 = A … bit6 = G, polarity per SEG_ACTIVE_LOW
- dp_o  out  1  decimal point segment, same polarity as seg_o
- dig_o  out  N_DIGITS  one-hot digit enables, polarity per DIG_ACTIVE_LOW
- frame_o  out  1  one-cycle pulse when slot index wraps to 0

Behaviour:
- Reset is sampled on a rising clk edge with reset == 0. It clears:
  - slot counter, digit index, and snapshot registers
  - outputs to inactive: seg_o and dp_o all off (all 1 when SEG_ACTIVE_LOW), dig_o all inactive, frame_o = 0
- Slot counter:
  - Runs 0..SCAN_DIV-1.
  - On terminal count it returns to 0 and the digit index advances 0→1→…→N_DIGITS-1→0.
  - Digit index wraps after N_DIGITS-1 regardless of the power-of-2 width.
- Snapshot:
  - digits_i, dp_i, lz_blank_i and bright_i are captured in the cycle where the digit index wraps to 0 (together with the frame_o pulse).
  - Also captured once in the first cycle after reset release.
  - Changes mid-frame are not visible until the next frame, so displays never tear.
- Decode:
  - Combinational from the snapshot and current index; all outputs are registered, so latency is 1 cycle after the index/sub-phase change.
  - Digit code 0..9 uses the standard font; 10..15 follow HEX_MODE.
  - Outputs are never X for any input code.
- Leading-zero suppression (lz_blank_i = 1): scanning from digit N_DIGITS-1 downward, a digit is blanked while:
  - every more-significant digit is a suppressed zero, and
  - its own code is 0 and its dp bit is 0.
  - Digit 0 is never suppressed, so the value 0 shows as a single "0".
- Brightness PWM:
  - Sub-phase = slot counter / (SCAN_DIV/8), range 0..7.
  - The digit enable is active only while sub-phase <= bright_i (snapshot value); segments stay driven.
  - bright_i = 0 gives 1/8 duty; bright_i = 7 gives full duty.
- Ghosting guard: on the first cycle of every slot, dig_o is forced inactive for that one cycle while seg_o switches to the new digit.
- Blanked digits (suppressed, or code 10 with HEX_MODE = 0) drive all segments off. dig_o still follows normal scan timing.

Decomposition:
- Shared package seg7_pkg holds:
  - 7-bit font constants: FONT_0..FONT_9, FONT_A..FONT_F, FONT_MINUS, FONT_BLANK (active-high, bit0 = A)
  - function seg7_decode(code, hex_mode) returning the active-high pattern
- Sub-module seg7_scan_timer (slot counter, digit index, sub-phase, frame pulse) is natural.
- Polarity inversion is applied once, at the output registers.

Test Plan (N_DIGITS = 4, SCAN_DIV = 16, HEX_MODE = 0, SEG_ACTIVE_LOW = 1, DIG_ACTIVE_LOW = 0):
1. Hold reset low 5 cycles with random inputs → seg_o = 7'h7F, dp_o = 1, dig_o = 4'b0000, frame_o = 0 throughout. After release, the first slot selects digit 0.
2. digits_i = 16'h1234, bright_i = 7 → dig_o sequence 0001,0010,0100,1000, each enabled 15 of 16 cycles (guard cycle). seg_o shows 4,3,2,1 respectively (digit 0 shows 4 = 7'h19). frame_o pulses every 64 cycles.
3. digits_i = 16'h0050, lz_blank_i = 1, dp_i = 4'b0000 → digits 3 and 2 show 7'h7F, digit 1 shows "5", digit 0 shows "0". Repeat with dp_i = 4'b1000 → digit 3 shows "0" with dp_o = 0, and digit 2 is no longer blanked.
4. bright_i = 0 → each digit enable active for cycle 1 only of its slot (cycle 0 is the guard). bright_i = 3 → active cycles 1..7 (sub-phases 0..3 span cycles 0..7, minus the guard).
5. Change digits_i from 16'h1111 to 16'h2222 while digit 2 is displayed → digit 3 still shows "1" this frame; all digits show "2" from the next frame_o onward. Code 11 shows 7'h3F (G only); code 15 shows blank.
6. Assert reset mid-slot with digit 2 active → outputs go inactive on the next edge. After release, scanning restarts at digit 0, slot count 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared font table and decode helper for the 7-segment scan driver.
// Fonts are active-high with bit0 = segment A and bit6 = segment G.
package seg7_pkg;

  localparam int N_SUBPHASES = 8;

  localparam logic [6:0] FONT_0     = 7'h3F;
  localparam logic [6:0] FONT_1     = 7'h06;
  localparam logic [6:0] FONT_2     = 7'h5B;
  localparam logic [6:0] FONT_3     = 7'h4F;
  localparam logic [6:0] FONT_4     = 7'h66;
  localparam logic [6:0] FONT_5     = 7'h6D;
  localparam logic [6:0] FONT_6     = 7'h7D;
  localparam logic [6:0] FONT_7     = 7'h07;
  localparam logic [6:0] FONT_8     = 7'h7F;
  localparam logic [6:0] FONT_9     = 7'h6F;
  localparam logic [6:0] FONT_A     = 7'h77;
  localparam logic [6:0] FONT_B     = 7'h7C;
  localparam logic [6:0] FONT_C     = 7'h39;
  localparam logic [6:0] FONT_D     = 7'h5E;
  localparam logic [6:0] FONT_E     = 7'h79;
  localparam logic [6:0] FONT_F     = 7'h71;
  localparam logic [6:0] FONT_MINUS = 7'h40;
  localparam logic [6:0] FONT_BLANK = 7'h00;

  // Symbol mode keeps 11 as a minus sign so signed readouts need no extra logic.
  function automatic logic [6:0] seg7_decode(input logic [3:0] code, input logic hex_mode);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = FONT_0;
      4'd1:    pattern = FONT_1;
      4'd2:    pattern = FONT_2;
      4'd3:    pattern = FONT_3;
      4'd4:    pattern = FONT_4;
      4'd5:    pattern = FONT_5;
      4'd6:    pattern = FONT_6;
      4'd7:    pattern = FONT_7;
      4'd8:    pattern = FONT_8;
      4'd9:    pattern = FONT_9;
      4'd10:   pattern = hex_mode ? FONT_A : FONT_BLANK;
      4'd11:   pattern = hex_mode ? FONT_B : FONT_MINUS;
      4'd12:   pattern = hex_mode ? FONT_C : FONT_BLANK;
      4'd13:   pattern = hex_mode ? FONT_D : FONT_BLANK;
      4'd14:   pattern = hex_mode ? FONT_E : FONT_BLANK;
      default: pattern = hex_mode ? FONT_F : FONT_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timing for the scan driver: sub-phase counter, digit index and frame wrap.
// A slot is N_SUBPHASES sub-phases of SCAN_DIV/N_SUBPHASES clocks each.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  localparam int IDX_W   = $clog2(N_DIGITS),
  localparam int SUB_LEN = SCAN_DIV / N_SUBPHASES,
  localparam int SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] digit_idx,
  output logic [2:0]       sub_phase,
  output logic             slot_start,
  output logic             frame_wrap
);

  logic [SUB_W-1:0] sub_cnt;
  logic             sub_last;
  logic             slot_last;
  logic             idx_last;

  assign sub_last   = (sub_cnt == SUB_W'(SUB_LEN - 1));
  assign slot_last  = sub_last && (sub_phase == 3'd7);
  assign idx_last   = (digit_idx == IDX_W'(N_DIGITS - 1));
  assign slot_start = (sub_cnt == '0) && (sub_phase == 3'd0);
  assign frame_wrap = slot_last && idx_last;

  // Explicit wrap at N_DIGITS-1 so non-power-of-2 digit counts never overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sub_cnt   <= '0;
      sub_phase <= 3'd0;
      digit_idx <= '0;
    end else if (slot_last) begin
      sub_cnt   <= '0;
      sub_phase <= 3'd0;
      digit_idx <= idx_last ? '0 : digit_idx + IDX_W'(1);
    end else if (sub_last) begin
      sub_cnt   <= '0;
      sub_phase <= sub_phase + 3'd1;
    end else begin
      sub_cnt   <= sub_cnt + SUB_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-coherent snapshot,
// leading-zero blanking, brightness PWM and a one-cycle ghosting guard.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  lz_blank_i,
  input  logic [2:0]            bright_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   dig_o,
  output logic                  frame_o
);

  localparam int   IDX_W   = $clog2(N_DIGITS);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  logic [IDX_W-1:0]      digit_idx;
  logic [2:0]            sub_phase;
  logic                  slot_start;
  logic                  frame_wrap;

  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic                  lz_q;
  logic [2:0]            bright_q;
  logic                  load_pending;

  logic [N_DIGITS-1:0]   suppress;
  logic [N_DIGITS-1:0]   cur_onehot;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_sup;
  logic [6:0]            cur_pattern;
  logic [N_DIGITS-1:0]   cur_dig;

  seg7_scan_timer #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .digit_idx  (digit_idx),
    .sub_phase  (sub_phase),
    .slot_start (slot_start),
    .frame_wrap (frame_wrap)
  );

  // Inputs are only sampled at frame boundaries (and once after reset) so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digits_q     <= '0;
      dp_q         <= '0;
      lz_q         <= 1'b0;
      bright_q     <= 3'd0;
      load_pending <= 1'b1;
    end else if (load_pending || frame_wrap) begin
      digits_q     <= digits_i;
      dp_q         <= dp_i;
      lz_q         <= lz_blank_i;
      bright_q     <= bright_i;
      load_pending <= 1'b0;
    end
  end

  // A zero with its dp set ends the leading run; digit 0 is never in it.
  always_comb begin
    logic leading;
    suppress = '0;
    leading  = lz_q;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (leading && (digits_q[4*i +: 4] == 4'd0) && !dp_q[i]) begin
        suppress[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end

  always_comb begin
    cur_code   = 4'd0;
    cur_dp     = 1'b0;
    cur_sup    = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == digit_idx) begin
        cur_code      = digits_q[4*i +: 4];
        cur_dp        = dp_q[i];
        cur_sup       = suppress[i];
        cur_onehot[i] = 1'b1;
      end
    end
    cur_pattern = cur_sup ? FONT_BLANK : seg7_decode(cur_code, HEX_MODE != 0);
    cur_dig     = (!slot_start && (sub_phase <= bright_q)) ? cur_onehot : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_o   <= {7{SEG_INV}};
      dp_o    <= SEG_INV;
      dig_o   <= {N_DIGITS{DIG_INV}};
      frame_o <= 1'b0;
    end else begin
      seg_o   <= cur_pattern ^ {7{SEG_INV}};
      dp_o    <= (cur_dp && !cur_sup) ^ SEG_INV;
      dig_o   <= cur_dig ^ {N_DIGITS{DIG_INV}};
      frame_o <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, SCAN_DIV=16 (2 clocks per sub-phase).
// Output sample k is taken on the falling edge after the k-th rising edge following reset release.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        lz_blank_i;
  logic [2:0]  bright_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  dig_o;
  logic        frame_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS       (4),
    .SCAN_DIV       (16),
    .HEX_MODE       (0),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .lz_blank_i (lz_blank_i),
    .bright_i   (bright_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .dig_o      (dig_o),
    .frame_o    (frame_o)
  );

  task automatic start_run(input logic [15:0] d, input logic [3:0] dp,
                           input logic lz, input logic [2:0] br);
    @(negedge clk);
    reset      = 1'b0;
    digits_i   = 16'($urandom);
    dp_i       = 4'($urandom);
    lz_blank_i = 1'($urandom);
    bright_i   = 3'($urandom);
    @(negedge clk);
    @(negedge clk);
    digits_i   = d;
    dp_i       = dp;
    lz_blank_i = lz;
    bright_i   = br;
    reset      = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      digits_i   = 16'($urandom);
      dp_i       = 4'($urandom);
      lz_blank_i = 1'($urandom);
      bright_i   = 3'($urandom);
      @(negedge clk);
      checks++;
      if (seg_o !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg c=%0d got %h expected 7f", c, seg_o); end
      checks++;
      if (dp_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp c=%0d got %b expected 1", c, dp_o); end
      checks++;
      if (dig_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dig c=%0d got %b expected 0000", c, dig_o); end
      checks++;
      if (frame_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame c=%0d got %b expected 0", c, frame_o); end
    end
    digits_i   = 16'h1234;
    dp_i       = 4'b0000;
    lz_blank_i = 1'b0;
    bright_i   = 3'd7;
    reset      = 1'b1;
    @(negedge clk);
    checks++;
    if (dig_o !== 4'b0000) begin errors++; $display("[TB] FAIL release_guard got %b expected 0000", dig_o); end
    @(negedge clk);
    checks++;
    if (dig_o !== 4'b0001) begin errors++; $display("[TB] FAIL release_first_digit got %b expected 0001", dig_o); end
    checks++;
    if (seg_o !== 7'h19) begin errors++; $display("[TB] FAIL release_first_seg got %h expected 19", seg_o); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_dig;
    int d, s;
    $display("[TB] test_scan");
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    start_run(16'h1234, 4'b0000, 1'b0, 3'd7);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      d = (k / 16) % 4;
      s = k % 16;
      exp_dig = (s != 0) ? 4'(1 << d) : 4'b0000;
      checks++;
      if (dig_o !== exp_dig) begin errors++; $display("[TB] FAIL scan_dig k=%0d got %b expected %b", k, dig_o, exp_dig); end
      checks++;
      if (frame_o !== (k % 64 == 63)) begin errors++; $display("[TB] FAIL scan_frame k=%0d got %b expected %b", k, frame_o, (k % 64 == 63)); end
      if (k >= 1) begin
        checks++;
        if (seg_o !== exp_seg[d]) begin errors++; $display("[TB] FAIL scan_seg k=%0d got %h expected %h", k, seg_o, exp_seg[d]); end
        checks++;
        if (dp_o !== 1'b1) begin errors++; $display("[TB] FAIL scan_dp k=%0d got %b expected 1", k, dp_o); end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_dp;
    logic [3:0] dp_req;
    int d;
    $display("[TB] test_lz_blank");
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        dp_req  = 4'b0000;
        exp_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        exp_dp  = 4'b1111;
      end else begin
        dp_req  = 4'b1000;
        exp_seg = '{7'h40, 7'h12, 7'h40, 7'h40};
        exp_dp  = 4'b0111;
      end
      start_run(16'h0050, dp_req, 1'b1, 3'd7);
      @(negedge clk);
      for (int k = 1; k < 64; k++) begin
        @(negedge clk);
        d = (k / 16) % 4;
        checks++;
        if (seg_o !== exp_seg[d]) begin errors++; $display("[TB] FAIL lz_seg pass=%0d k=%0d got %h expected %h", pass, k, seg_o, exp_seg[d]); end
        checks++;
        if (dp_o !== exp_dp[d]) begin errors++; $display("[TB] FAIL lz_dp pass=%0d k=%0d got %b expected %b", pass, k, dp_o, exp_dp[d]); end
      end
    end
  endtask

  task automatic test_brightness();
    logic [2:0] br;
    logic [3:0] exp_dig;
    int d, s, last_on;
    $display("[TB] test_brightness");
    for (int n = 0; n < 2; n++) begin
      br      = (n == 0) ? 3'd0 : 3'd3;
      last_on = (n == 0) ? 1 : 7;
      start_run(16'h1234, 4'b0000, 1'b0, br);
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        d = (k / 16) % 4;
        s = k % 16;
        exp_dig = (s >= 1 && s <= last_on) ? 4'(1 << d) : 4'b0000;
        checks++;
        if (dig_o !== exp_dig) begin errors++; $display("[TB] FAIL bright_dig br=%0d k=%0d got %b expected %b", br, k, dig_o, exp_dig); end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] exp;
    $display("[TB] test_snapshot");
    start_run(16'h1111, 4'b0000, 1'b0, 3'd7);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      exp = (k < 64) ? 7'h79 : 7'h24;
      if (k >= 1) begin
        checks++;
        if (seg_o !== exp) begin errors++; $display("[TB] FAIL snap_seg k=%0d got %h expected %h", k, seg_o, exp); end
      end
      if (k == 40) digits_i = 16'h2222;
    end
  endtask

  task automatic test_symbol_codes();
    logic [6:0] exp_seg [4];
    int d;
    $display("[TB] test_symbol_codes");
    exp_seg = '{7'h3F, 7'h7F, 7'h3F, 7'h7F};
    start_run(16'hFBAB, 4'b0000, 1'b0, 3'd7);
    @(negedge clk);
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      d = (k / 16) % 4;
      checks++;
      if (seg_o !== exp_seg[d]) begin errors++; $display("[TB] FAIL code_seg k=%0d got %h expected %h", k, seg_o, exp_seg[d]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_dig;
    $display("[TB] test_mid_reset");
    start_run(16'h1234, 4'b0000, 1'b0, 3'd7);
    for (int k = 0; k <= 40; k++) @(negedge clk);
    checks++;
    if (dig_o !== 4'b0100) begin errors++; $display("[TB] FAIL midrst_pre_dig got %b expected 0100", dig_o); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (seg_o !== 7'h7F) begin errors++; $display("[TB] FAIL midrst_seg got %h expected 7f", seg_o); end
    checks++;
    if (dp_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_dp got %b expected 1", dp_o); end
    checks++;
    if (dig_o !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_dig got %b expected 0000", dig_o); end
    checks++;
    if (frame_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_frame got %b expected 0", frame_o); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      exp_dig = (k == 0 || k == 16) ? 4'b0000 : ((k < 16) ? 4'b0001 : 4'b0010);
      checks++;
      if (dig_o !== exp_dig) begin errors++; $display("[TB] FAIL restart_dig k=%0d got %b expected %b", k, dig_o, exp_dig); end
      checks++;
      if (frame_o !== 1'b0) begin errors++; $display("[TB] FAIL restart_frame k=%0d got %b expected 0", k, frame_o); end
      if (k >= 1 && k < 16) begin
        checks++;
        if (seg_o !== 7'h19) begin errors++; $display("[TB] FAIL restart_seg k=%0d got %h expected 19", k, seg_o); end
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    digits_i   = 16'h0000;
    dp_i       = 4'b0000;
    lz_blank_i = 1'b0;
    bright_i   = 3'd0;
    test_reset();
    test_scan();
    test_lz_blank();
    test_brightness();
    test_snapshot();
    test_symbol_codes();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
